// File: rtl/tt_frame_loader_pkg.sv
// tt_frame_loader_pkg: shared state encoding, limits and byte-field helpers for the frame loader
package tt_frame_loader_pkg;
  localparam int DEF_MAX_EDGES = 15;
  localparam int DEF_TIMEOUT = 1023;
  localparam int BYTE_W = 8;
  localparam int STN_W = 4;
  localparam int SRC_LSB = 4;
  localparam int DST_LSB = 0;
  localparam int WD_W = 10;
  localparam int PTR_W = 4;
  typedef enum logic [2:0] {HDR, CNT, LOAD, SEND, WAIT} state_t;
  function automatic logic [STN_W-1:0] src_of(input logic [BYTE_W-1:0] b);
    return b[SRC_LSB +: STN_W];
  endfunction
  function automatic logic [STN_W-1:0] dst_of(input logic [BYTE_W-1:0] b);
    return b[DST_LSB +: STN_W];
  endfunction
endpackage

// File: rtl/tt_edge_buf.sv
// tt_edge_buf: 16x8 edge register file, synchronous write, combinational read, no reset
module tt_edge_buf
  import tt_frame_loader_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [BYTE_W-1:0] rd_data
);
  logic [BYTE_W-1:0] mem [2**PTR_W];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/tt_frame_loader.sv
// tt_frame_loader: collects a query plus N edge bytes from the host, replays them to the tour-cost core and waits for completion
module tt_frame_loader
  import tt_frame_loader_pkg::*;
#(
  parameter int MAX_EDGES = DEF_MAX_EDGES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  input  logic [BYTE_W-1:0] host_data,
  output logic              host_ready,
  output logic              in_valid,
  output logic [STN_W-1:0]  source,
  output logic [STN_W-1:0]  destination,
  input  logic              out_valid,
  output logic              done,
  output logic              frame_err,
  output logic              timeout
);
  state_t state;
  logic [BYTE_W-1:0] query, rd_data;
  logic [PTR_W-1:0] n, ptr;
  logic [WD_W-1:0] wdog;
  logic acc, cnt_ok;
  assign host_ready = state == HDR || state == CNT || state == LOAD;
  assign acc = host_valid && host_ready;
  assign cnt_ok = host_data != '0 && host_data <= BYTE_W'(MAX_EDGES);
  // one pointer serves both the load writes and the replay reads
  tt_edge_buf u_buf (
    .clk(clk), .wr_en(acc && state == LOAD), .wr_addr(ptr), .wr_data(host_data),
    .rd_addr(ptr), .rd_data(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HDR;
      query <= '0;
      n <= '0;
      ptr <= '0;
      wdog <= '0;
      in_valid <= 1'b0;
      source <= '0;
      destination <= '0;
      done <= 1'b0;
      frame_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      frame_err <= 1'b0;
      timeout <= 1'b0;
      in_valid <= 1'b0;
      source <= '0;
      destination <= '0;
      case (state)
        HDR: if (acc) begin
          query <= host_data;
          state <= CNT;
        end
        CNT: if (acc) begin
          if (cnt_ok) begin
            n <= host_data[PTR_W-1:0];
            ptr <= '0;
            state <= LOAD;
          end else begin
            frame_err <= 1'b1;
            query <= '0;
            state <= HDR;
          end
        end
        LOAD: if (acc) begin
          if (ptr == n - 1'b1) begin
            ptr <= '0;
            state <= SEND;
            in_valid <= 1'b1;
            source <= src_of(query);
            destination <= dst_of(query);
          end else ptr <= ptr + 1'b1;
        end
        SEND: if (ptr == n) begin
          state <= WAIT;
          wdog <= '0;
        end else begin
          in_valid <= 1'b1;
          source <= src_of(rd_data);
          destination <= dst_of(rd_data);
          ptr <= ptr + 1'b1;
        end
        WAIT: if (out_valid) begin
          done <= 1'b1;
          state <= HDR;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          timeout <= 1'b1;
          wdog <= WD_W'(TIMEOUT);
          state <= HDR;
        end else if (wdog != '1) wdog <= wdog + 1'b1;
        default: state <= HDR;
      endcase
    end
endmodule

// File: tb/tb_tt_frame_loader.sv
// tb_tt_frame_loader: table-driven and randomized frame checks against a frame-level reference model
module tb_tt_frame_loader;
  localparam int TO = 1023;
  logic clk = 0, rst_n = 0, host_valid = 0, out_valid = 0;
  logic host_ready, in_valid, done, frame_err, timeout;
  logic [7:0] host_data = 0;
  logic [3:0] source, destination;
  int cyc = 0, errors = 0, checks = 0;
  int obs_t[$], done_t[$], err_t[$], to_t[$];
  logic [7:0] obs_v[$];
  bit noise = 0;

  tt_frame_loader #(.MAX_EDGES(15), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .in_valid(in_valid), .source(source),
    .destination(destination), .out_valid(out_valid), .done(done),
    .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (in_valid) begin
      obs_v.push_back({source, destination});
      obs_t.push_back(cyc);
      chk("ready_low_in_send", int'(host_ready), 0);
    end else chk("idle_src_dst_zero", int'({source, destination}), 0);
    if (done) done_t.push_back(cyc);
    if (frame_err) err_t.push_back(cyc);
    if (timeout) to_t.push_back(cyc);
  end

  task automatic step(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic clear_obs();
    obs_v.delete(); obs_t.delete(); done_t.delete(); err_t.delete(); to_t.delete();
  endtask

  task automatic put(input logic [7:0] b, input int gap, output int t);
    repeat (gap) begin
      host_valid = 0;
      host_data = 8'($urandom);
      out_valid = noise && ($urandom_range(0, 1) == 1);
      step();
    end
    out_valid = 0;
    chk("host_ready_accept", int'(host_ready), 1);
    host_valid = 1;
    host_data = b;
    t = cyc;
    step();
    host_valid = 0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] q, input logic [7:0] cnt,
      input logic [119:0] ed, input int d, input bit rnd, input bit exp_err, input bit exp_to);
    int t, n, e_ent, lim;
    logic [7:0] exp_v[$];
    clear_obs();
    noise = rnd;
    put(q, rnd ? int'($urandom_range(0, 3)) : 0, t);
    put(cnt, rnd ? int'($urandom_range(0, 3)) : 0, t);
    if (exp_err) begin
      step(2);
      chk({tag, "_err_count"}, err_t.size(), 1);
      if (err_t.size() > 0) chk({tag, "_err_cycle"}, err_t[0], t + 1);
      chk({tag, "_err_no_send"}, obs_v.size(), 0);
      return;
    end
    n = int'(cnt);
    exp_v.push_back(q);
    for (int i = 0; i < n; i++) begin
      exp_v.push_back(ed[8*i +: 8]);
      put(ed[8*i +: 8], rnd ? int'($urandom_range(0, 3)) : 0, t);
    end
    noise = 0;
    e_ent = t + n + 2;
    if (d >= 0) begin
      while (cyc < e_ent + d) begin
        host_valid = rnd && ($urandom_range(0, 1) == 1);
        host_data = 8'($urandom);
        step();
      end
      host_valid = 0;
      out_valid = 1;
      step();
      out_valid = 0;
    end
    host_valid = 0;
    lim = exp_to ? e_ent + (d > TO ? d : TO) + 3 : e_ent + d + 3;
    while (cyc < lim) step();
    chk({tag, "_send_len"}, obs_v.size(), n + 1);
    for (int i = 0; i < obs_v.size() && i <= n; i++) begin
      chk({tag, "_send_val"}, int'(obs_v[i]), int'(exp_v[i]));
      chk({tag, "_send_cycle"}, obs_t[i], t + 1 + i);
    end
    chk({tag, "_no_err"}, err_t.size(), 0);
    chk({tag, "_done_count"}, done_t.size(), exp_to ? 0 : 1);
    if (!exp_to && done_t.size() > 0) chk({tag, "_done_cycle"}, done_t[0], e_ent + d + 1);
    chk({tag, "_to_count"}, to_t.size(), exp_to ? 1 : 0);
    if (exp_to && to_t.size() > 0) chk({tag, "_to_cycle"}, to_t[0], e_ent + TO);
  endtask

  typedef struct {
    logic [7:0] q;
    logic [7:0] cnt;
    logic [119:0] ed;
    int d;
    bit rnd;
    bit err;
    bit to;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int t;
    logic [127:0] rbits;
    logic [7:0] rq, rc;
    int rd;
    tbl[0] = '{8'h3A, 8'h02, 120'h4512, 5, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h77, 8'h00, 120'h0, 0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h77, 8'h10, 120'h0, 0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'hC5, 8'h01, 120'hE9, 0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h11, 8'h0F, 120'hEFCDAB8967452301F1E2D3C4B5A697, 3, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hF0, 8'h03, 120'h332211, -1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{8'h0F, 8'h02, 120'hBBAA, TO - 1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{8'h5A, 8'h04, 120'h44332211, TO, 1'b0, 1'b0, 1'b1};

    step(3);
    chk("reset_in_valid", int'(in_valid), 0);
    chk("reset_src_dst", int'({source, destination}), 0);
    chk("reset_pulses", int'({done, frame_err, timeout}), 0);
    @(negedge clk) rst_n = 1;
    step();
    chk("ready_after_release", int'(host_ready), 1);

    for (int i = 0; i < 8; i++) run_frame($sformatf("tbl%0d", i), tbl[i].q, tbl[i].cnt,
        tbl[i].ed, tbl[i].d, tbl[i].rnd, tbl[i].err, tbl[i].to);

    clear_obs();
    put(8'h96, 0, t);
    put(8'h03, 0, t);
    put(8'h21, 0, t);
    put(8'h43, 0, t);
    put(8'h65, 0, t);
    step(2);
    chk("pre_reset_send", int'(in_valid), 1);
    rst_n = 0;
    #1;
    chk("async_drop_in_valid", int'(in_valid), 0);
    chk("async_drop_src_dst", int'({source, destination}), 0);
    step(2);
    @(negedge clk) rst_n = 1;
    step();
    chk("ready_after_mid_reset", int'(host_ready), 1);
    step(3);
    chk("no_done_after_reset", done_t.size(), 0);
    run_frame("post_reset", 8'hAB, 8'h02, 120'hCDEF, 2, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      rbits = {$urandom, $urandom, $urandom, $urandom};
      rq = 8'($urandom);
      rc = 8'($urandom_range(0, 17));
      if ($urandom_range(0, 3) != 0) rc = 8'($urandom_range(1, 15));
      rd = (f % 10 == 9) ? -1 : int'($urandom_range(0, 30));
      run_frame($sformatf("rnd%0d", f), rq, rc, rbits[119:0], rd, 1'b1,
          rc == 0 || rc > 15, rd < 0 || rd >= TO);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1);
  end
endmodule
